// File: rtl/fifo_uart_pkg.sv
// Shared types for the FIFO-fed UART transmitter: state encodings and data width.
package fifo_uart_pkg;

  localparam int UART_DATA_W = 8;
  localparam int BIT_IDX_W   = 3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    PARITY = 3'd5,
    STOP   = 3'd6
  } uart_state_e;

endpackage

// File: rtl/baud_tick_gen.sv
// Free-running bit-period counter; tick marks the last cycle of each UART bit.
module baud_tick_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Wrapping on tick restarts the count at every bit boundary without help from the FSM.
  always_comb begin
    tick  = (cnt_q == LAST);
    cnt_d = (clear || tick) ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from the FIFO read port and sends each as an 8N1 UART frame.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data bit 7 and stop.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tx_en,
  input  logic                   fifo_empty,
  input  logic [UART_DATA_W-1:0] fifo_data,
  output logic                   fifo_rd_en,
  output logic                   tx,
  output logic                   busy,
  output logic [15:0]            frame_cnt
);

  uart_state_e            state_q, state_d;
  logic [UART_DATA_W-1:0] shift_q, shift_d;
  logic [BIT_IDX_W-1:0]   bit_idx_q, bit_idx_d;
  logic                   tx_q, tx_d;
  logic                   rd_en_q, rd_en_d;
  logic                   busy_q, busy_d;
  logic [15:0]            frame_cnt_q, frame_cnt_d;
`ifdef UART_TX_PARITY_EN
  logic                   parity_q, parity_d;
`endif

  logic baud_clear;
  logic tick;

  // Hold the counter at zero until the frame starts so START gets a full bit period.
  assign baud_clear = (state_q == IDLE) || (state_q == FETCH) || (state_q == LOAD);

  baud_tick_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk   (clk),
    .rst   (rst),
    .clear (baud_clear),
    .tick  (tick)
  );

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_idx_d   = bit_idx_q;
    frame_cnt_d = frame_cnt_q;
`ifdef UART_TX_PARITY_EN
    parity_d    = parity_q;
`endif
    case (state_q)
      IDLE:  if (tx_en && !fifo_empty) state_d = FETCH;
      FETCH: state_d = LOAD;
      LOAD: begin
        shift_d   = fifo_data;
        bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
        parity_d  = ^fifo_data;
`endif
        state_d   = START;
      end
      START: if (tick) state_d = DATA;
      DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bit_idx_q == BIT_IDX_W'(UART_DATA_W - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (tick) state_d = STOP;
`endif
      STOP: begin
        if (tick) begin
          frame_cnt_d = frame_cnt_q + 16'd1;
          state_d     = (tx_en && !fifo_empty) ? FETCH : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they are registered with it.
    rd_en_d = (state_d == FETCH);
    busy_d  = (state_d != IDLE);
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = parity_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      bit_idx_q   <= '0;
      tx_q        <= 1'b1;
      rd_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      frame_cnt_q <= '0;
`ifdef UART_TX_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_idx_q   <= bit_idx_d;
      tx_q        <= tx_d;
      rd_en_q     <= rd_en_d;
      busy_q      <= busy_d;
      frame_cnt_q <= frame_cnt_d;
`ifdef UART_TX_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

  assign fifo_rd_en = rd_en_q;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with a behavioural FIFO read port and a bit-level frame checker.
module tb_fifo_uart_tx;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tx_en = 1'b0;
  logic        fifo_empty = 1'b1;
  logic [7:0]  fifo_data = 8'h00;
  logic        fifo_rd_en;
  logic        tx;
  logic        busy;
  logic [15:0] frame_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int rd_cnt = 0;
  int underflow = 0;
  int busy_drops = 0;
  bit mon_busy = 1'b0;

  logic [7:0] mem[$];
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_en      (tx_en),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd_en (fifo_rd_en),
    .tx         (tx),
    .busy       (busy),
    .frame_cnt  (frame_cnt)
  );

  // FIFO read side: registered data_out, empty updated after each write/pop edge.
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      rd_cnt++;
      if (mem.size() == 0) underflow++;
      else fifo_data <= mem.pop_front();
    end
    fifo_empty <= (mem.size() == 0);
  end

  always @(negedge clk) begin
    if (mon_busy && !busy) busy_drops++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [7:0] b);
    @(negedge clk);
    mem.push_back(b);
    exp_q.push_back(b);
  endtask

  // Waits for a start bit, then checks every sample of the frame; gap = idle-high samples before it.
  task automatic rx_frame(input string tag, output int gap);
    logic [7:0]  b;
    logic [10:0] f;
    bit          seen;
    seen = 1'b0;
    gap  = 0;
    b    = 8'h00;
    check_eq({tag, "_have_exp"}, (exp_q.size() > 0), 1);
    if (exp_q.size() > 0) b = exp_q.pop_front();
    f        = '1;
    f[0]     = 1'b0;
    f[8:1]   = b;
`ifdef UART_TX_PARITY_EN
    f[9]     = ^b;
`endif
    while (!seen && gap < 500) begin
      @(negedge clk);
      if (tx === 1'b0) seen = 1'b1;
      else gap++;
    end
    check_eq({tag, "_start_seen"}, seen, 1);
    if (seen) begin
      for (int i = 0; i < NBITS; i++) begin
        for (int j = 0; j < CPB; j++) begin
          if (i != 0 || j != 0) @(negedge clk);
          check_eq($sformatf("%s_bit%0d", tag, i), tx, f[i]);
        end
      end
    end
  endtask

  initial begin
    int g;
    int rd0;
    bit seen;
    int wcnt;

    wait_neg(3);
    check_eq("rst_tx", tx, 1);
    check_eq("rst_rd_en", fifo_rd_en, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_frame_cnt", frame_cnt, 0);
    rst   = 1'b0;
    tx_en = 1'b1;

    // single byte
    rd0 = rd_cnt;
    push(8'hA5);
    rx_frame("single", g);
    wait_neg(1);
    check_eq("single_rd_pulses", rd_cnt - rd0, 1);
    check_eq("single_frame_cnt", frame_cnt, 1);
    check_eq("single_busy_idle", busy, 0);

    // gating by tx_en
    tx_en = 1'b0;
    push(8'h55);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check_eq("gate_rd_en", fifo_rd_en, 0);
      check_eq("gate_tx", tx, 1);
    end
    tx_en = 1'b1;
    @(negedge clk);
    check_eq("gate_fetch_rd_en", fifo_rd_en, 1);
    @(negedge clk);
    check_eq("gate_load_tx", tx, 1);
    check_eq("gate_load_rd_en", fifo_rd_en, 0);
    rx_frame("gate", g);
    check_eq("gate_latency_gap", g, 0);
    wait_neg(1);
    check_eq("gate_frame_cnt", frame_cnt, 2);

    // burst of three back-to-back frames
    tx_en = 1'b0;
    rst   = 1'b1;
    wait_neg(2);
    rst = 1'b0;
    push(8'h00);
    push(8'hFF);
    push(8'h3C);
    wait_neg(3);
    tx_en = 1'b1;
    wait_neg(2);
    mon_busy = 1'b1;
    rx_frame("burst0", g);
    rx_frame("burst1", g);
    check_eq("burst1_gap", g, 2);
    rx_frame("burst2", g);
    check_eq("burst2_gap", g, 2);
    mon_busy = 1'b0;
    wait_neg(1);
    check_eq("burst_frame_cnt", frame_cnt, 3);
    check_eq("burst_busy_drops", busy_drops, 0);
    check_eq("burst_fifo_empty", fifo_empty, 1);
    check_eq("burst_fifo_level", mem.size(), 0);

    // parity / frame length patterns
    tx_en = 1'b0;
    push(8'h07);
    push(8'h03);
    wait_neg(3);
    tx_en = 1'b1;
    rx_frame("par07", g);
    rx_frame("par03", g);
    check_eq("par03_gap", g, 2);
    wait_neg(1);
    check_eq("par_frame_cnt", frame_cnt, 5);

    // reset during data bit 3
    tx_en = 1'b0;
    push(8'h5A);
    push(8'hC3);
    push(8'h81);
    wait_neg(3);
    tx_en = 1'b1;
    seen = 1'b0;
    wcnt = 0;
    while (!seen && wcnt < 500) begin
      @(negedge clk);
      if (tx === 1'b0) seen = 1'b1;
      else wcnt++;
    end
    check_eq("mid_start_seen", seen, 1);
    wait_neg(17);
    rst = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_tx", tx, 1);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_rd_en", fifo_rd_en, 0);
    rst = 1'b0;
    void'(exp_q.pop_front());
    rx_frame("mid_c3", g);
    rx_frame("mid_81", g);
    check_eq("mid_81_gap", g, 2);
    wait_neg(1);
    check_eq("mid_frame_cnt", frame_cnt, 2);
    check_eq("mid_fifo_level", mem.size(), 0);

    // frame counter wrap
    @(negedge clk);
    force dut.frame_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.frame_cnt_q;
    @(negedge clk);
    check_eq("wrap_preset", frame_cnt, 16'hFFFF);
    push(8'h3C);
    rx_frame("wrap", g);
    wait_neg(1);
    check_eq("wrap_frame_cnt", frame_cnt, 0);

    check_eq("no_underflow", underflow, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Read-side consumer for the 8-bit synchronous FIFO: pops bytes whenever the FIFO is non-empty and serialises each one as an asynchronous UART frame on a single `tx` line. It sits after `fifo_top`, whose write port is fed by upstream logic. Its `read_en`/`data_out`/`empty` connect directly to this block. The block owns all FIFO read timing, so upstream logic only ever writes.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per UART bit; legal range 2..65535.
- `clk`  in  1: single clock; all logic is rising-edge.
- `rst`  in  1: synchronous, active-high reset.
- `tx_en`  in  1: permission to start new frames; a frame already in flight always completes.
- `fifo_empty`  in  1: FIFO `empty` flag.
- `fifo_data`  in  8: FIFO `data_out`; valid the cycle after `fifo_rd_en` is high.
- `fifo_rd_en`  out  1: FIFO `read_en`; registered; one-cycle pulse per byte.
- `tx`  out  1: serial line; idle high; registered.
- `busy`  out  1: high in every state except IDLE.
- `frame_cnt`  out  16: count of completed frames; wraps from 0xFFFF to 0x0000.

## Operation
- States: IDLE, FETCH, LOAD, START, DATA, PARITY (only when compiled in), STOP.
- IDLE → FETCH when `tx_en`=1 and `fifo_empty`=0; otherwise stay in IDLE with `tx`=1.
- FETCH: `fifo_rd_en`=1 for exactly this cycle. Always → LOAD.
- LOAD: capture `fifo_data` into the 8-bit shift register and clear the bit index. Always → START.
- START: `tx`=0 for CLKS_PER_BIT cycles → DATA.
- DATA: `tx` = shift[0], LSB first. Each bit lasts CLKS_PER_BIT cycles, then shift right. After bit 7 → PARITY, or → STOP when parity is compiled out.
- PARITY: `tx` = XOR of the 8 captured bits (even parity), for CLKS_PER_BIT cycles → STOP.
- STOP: `tx`=1 for CLKS_PER_BIT cycles. On the last cycle, `frame_cnt` increments; go to FETCH if `tx_en`=1 and `fifo_empty`=0, else to IDLE.
- Baud counter: width $clog2(CLKS_PER_BIT).
  - Cleared on entry to START, PARITY and STOP, and at every DATA bit boundary.
  - The bit ends when the counter equals CLKS_PER_BIT-1.
- `fifo_rd_en` is never asserted while `fifo_empty`=1, so an underflow pop is impossible by construction.
- `tx_en` falling mid-frame has no effect until the next decision point (IDLE or the last cycle of STOP).

## Timing
- Reset values: `tx`=1, `fifo_rd_en`=0, `busy`=0, `frame_cnt`=0, state IDLE, shift register 0, counters 0.
- Reset mid-frame: on the next cycle `tx`=1 and the state is IDLE. The popped byte is discarded; the FIFO is not rewound.
- `fifo_empty` falls with the block in IDLE at cycle T:
  - `fifo_rd_en` is high at T+1.
  - Data is captured at the end of T+2.
  - `tx`=0 from T+3.
- Frame length: 10×CLKS_PER_BIT cycles, or 11×CLKS_PER_BIT with parity.
- Back-to-back frames: exactly 2 extra `tx`-high cycles (FETCH, LOAD) after the stop bit.
- `busy` is high from FETCH through the last STOP cycle.

## Configuration
- `UART_TX_PARITY_EN` defined: the PARITY state exists and an even-parity bit is inserted between bit 7 and the stop bit.
- `UART_TX_PARITY_EN` undefined: there is no PARITY state and DATA goes directly to STOP. All other timing is unchanged.

## Structure
- Package `fifo_uart_pkg` holds:
  - the state enum typedef;
  - `UART_DATA_W`=8;
  - state encodings.
- Sub-module `baud_tick_gen`:
  - inputs `clk`, `rst`, `clear`;
  - output `tick`, high on count CLKS_PER_BIT-1;
  - parameterised by CLKS_PER_BIT.

## Test plan
- Single byte: CLKS_PER_BIT=4, write 0xA5 into the FIFO. Required response:
  - one `fifo_rd_en` pulse;
  - `tx` = 0,1,0,1,0,0,1,0,1 (start then LSB-first data), then parity 0 if enabled, then stop 1, each bit 4 cycles;
  - `frame_cnt`=1.
- Burst: preload 0x00, 0xFF, 0x3C. Required response:
  - three frames with exactly 2 idle-high cycles between them;
  - `busy` continuously high;
  - FIFO `empty` at the end;
  - `frame_cnt`=3.
- Gating: 0x55 queued with `tx_en`=0 → no `fifo_rd_en` and `tx` stays 1. Raise `tx_en` → frame starts 3 cycles later.
- Reset mid-frame: assert `rst` during DATA bit 3. Required response:
  - the next cycle has `tx`=1, `busy`=0, `fifo_rd_en`=0;
  - the remaining FIFO bytes are sent correctly after release.
- Counter wrap: force `frame_cnt`=0xFFFF, send one byte → 0x0000.
- Parity: with `UART_TX_PARITY_EN` defined, 0x07 → parity bit 1 and 0x03 → parity bit 0. Without it, the frame is 10×CLKS_PER_BIT cycles.
